// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the Fetch port, the load/store port and the shared memory bus
// as seen by mem_bus_arbiter; the arbiter uses master, its surroundings use slave.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              i_imem_req;
  logic [ADDR_W-1:0] i_imem_addr;
  logic              o_imem_rdy;
  logic              o_imem_vld;
  logic [31:0]       o_imem_rdata;
  logic              i_flush;

  logic              i_dmem_req;
  logic              i_dmem_we;
  logic [ADDR_W-1:0] i_dmem_addr;
  logic [31:0]       i_dmem_wdata;
  logic [3:0]        i_dmem_wstrb;
  logic              o_dmem_rdy;
  logic              o_dmem_vld;
  logic [31:0]       o_dmem_rdata;

  logic              o_bus_req;
  logic              o_bus_we;
  logic [ADDR_W-1:0] o_bus_addr;
  logic [31:0]       o_bus_wdata;
  logic [3:0]        o_bus_wstrb;
  logic              i_bus_gnt;
  logic              i_bus_rvld;
  logic [31:0]       i_bus_rdata;

  logic              o_busy;

  modport master (
    input  i_imem_req, i_imem_addr, i_flush,
    input  i_dmem_req, i_dmem_we, i_dmem_addr, i_dmem_wdata, i_dmem_wstrb,
    input  i_bus_gnt, i_bus_rvld, i_bus_rdata,
    output o_imem_rdy, o_imem_vld, o_imem_rdata,
    output o_dmem_rdy, o_dmem_vld, o_dmem_rdata,
    output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wstrb,
    output o_busy
  );

  modport slave (
    output i_imem_req, i_imem_addr, i_flush,
    output i_dmem_req, i_dmem_we, i_dmem_addr, i_dmem_wdata, i_dmem_wstrb,
    output i_bus_gnt, i_bus_rvld, i_bus_rdata,
    input  o_imem_rdy, o_imem_vld, o_imem_rdata,
    input  o_dmem_rdy, o_dmem_vld, o_dmem_rdata,
    input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wstrb,
    input  o_busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding memory bus shared by Fetch and load/store; data has
// priority, and a starvation counter forces an instruction grant.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_e;
  typedef enum logic {OWN_INSTR, OWN_DATA} owner_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e            r_state;
  owner_e            r_owner;
  logic [3:0]        r_starve_cnt;
  logic              r_drop;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_imem_vld;
  logic [31:0]       r_imem_rdata;
  logic              r_dmem_vld;
  logic [31:0]       r_dmem_rdata;

  logic w_idle;
  logic w_starved;
  logic w_instr_flush;
  logic w_grant_i;
  logic w_grant_d;

  // rst_n is active-high here; no grant may be handed out during a reset cycle.
  assign w_idle        = (r_state == S_IDLE) && !rst_n;
  assign w_starved     = (r_starve_cnt == STARVE_MAX);
  assign w_instr_flush = (r_owner == OWN_INSTR) && bus.i_flush;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned and a latch is never inferred.
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (w_idle) begin
      if (bus.i_imem_req && !bus.i_flush && (!bus.i_dmem_req || w_starved))
        w_grant_i = 1'b1;
      else if (bus.i_dmem_req)
        w_grant_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_INSTR;
      r_starve_cnt <= '0;
      r_drop       <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_imem_vld   <= 1'b0;
      r_imem_rdata <= '0;
      r_dmem_vld   <= 1'b0;
      r_dmem_rdata <= '0;
    end else begin
      r_imem_vld <= 1'b0;
      r_dmem_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_drop <= 1'b0;
          if (w_grant_i) begin
            r_owner      <= OWN_INSTR;
            r_we         <= 1'b0;
            r_addr       <= bus.i_imem_addr;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_starve_cnt <= '0;
            r_state      <= S_REQ;
          end else if (w_grant_d) begin
            r_owner <= OWN_DATA;
            r_we    <= bus.i_dmem_we;
            r_addr  <= bus.i_dmem_addr;
            r_wdata <= bus.i_dmem_wdata;
            r_wstrb <= bus.i_dmem_wstrb;
            if (bus.i_imem_req && !w_starved)
              r_starve_cnt <= r_starve_cnt + 4'd1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          // An ungranted fetch can simply be withdrawn; a granted one must be drained.
          if (w_instr_flush && !bus.i_bus_gnt) begin
            r_state <= S_IDLE;
          end else if (bus.i_bus_gnt) begin
            if (w_instr_flush) r_drop <= 1'b1;
            r_state <= S_RSP;
          end
        end
        S_RSP: begin
          if (bus.i_bus_rvld) begin
            r_state <= S_IDLE;
            r_drop  <= 1'b0;
            if (r_owner == OWN_INSTR) begin
              if (!r_drop && !bus.i_flush) begin
                r_imem_vld   <= 1'b1;
                r_imem_rdata <= bus.i_bus_rdata;
              end
            end else begin
              r_dmem_vld   <= 1'b1;
              r_dmem_rdata <= r_we ? 32'h0 : bus.i_bus_rdata;
            end
          end else if (w_instr_flush) begin
            r_drop <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_imem_rdy   = w_grant_i;
  assign bus.o_dmem_rdy   = w_grant_d;
  assign bus.o_imem_vld   = r_imem_vld;
  assign bus.o_imem_rdata = r_imem_rdata;
  assign bus.o_dmem_vld   = r_dmem_vld;
  assign bus.o_dmem_rdata = r_dmem_rdata;
  assign bus.o_bus_req    = (r_state == S_REQ);
  assign bus.o_bus_we     = r_we;
  assign bus.o_bus_addr   = r_addr;
  assign bus.o_bus_wdata  = r_wdata;
  assign bus.o_bus_wstrb  = r_wstrb;
  assign bus.o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a reactive bus model plus a response
// scoreboard that is filled at each rdy and drained at each vld.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(32)) bus_if ();

  mem_bus_arbiter #(
    .STARVE_LIMIT (4),
    .ADDR_W       (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] imem_q[$];
  logic [31:0] dmem_q[$];

  // Bus side: either the automatic responder or manual values from the sequence.
  logic        auto_bus  = 1'b1;
  logic        a_gnt     = 1'b0;
  logic        a_rvld    = 1'b0;
  logic [31:0] a_rdata   = '0;
  logic        m_gnt     = 1'b0;
  logic        m_rvld    = 1'b0;
  logic [31:0] m_rdata   = '0;
  logic        pend      = 1'b0;
  logic [31:0] pend_addr = '0;

  assign bus_if.i_bus_gnt   = auto_bus ? a_gnt   : m_gnt;
  assign bus_if.i_bus_rvld  = auto_bus ? a_rvld  : m_rvld;
  assign bus_if.i_bus_rdata = auto_bus ? a_rdata : m_rdata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h0013_0313;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic wait_dvld(input int max_cyc, input string tag);
    int n = 0;
    probe();
    while (bus_if.o_dmem_vld !== 1'b1 && n < max_cyc) begin
      tick();
      probe();
      n++;
    end
    check(tag, 32'(bus_if.o_dmem_vld), 32'd1);
  endtask

  // Grant on the first cycle a request is seen, respond on the next one.
  always @(negedge clk) begin
    a_gnt  = 1'b0;
    a_rvld = 1'b0;
    if (auto_bus) begin
      if (pend) begin
        a_rvld = 1'b1;
        a_rdata = mem_word(pend_addr);
        pend = 1'b0;
      end else if (bus_if.o_bus_req === 1'b1) begin
        a_gnt = 1'b1;
        pend = 1'b1;
        pend_addr = bus_if.o_bus_addr;
      end
    end
  end

  always @(negedge clk) begin
    if (bus_if.o_imem_vld === 1'b1) begin
      if (imem_q.size() == 0) check("imem_unexpected_vld", 32'(bus_if.o_imem_vld), 32'd0);
      else check("imem_rdata", bus_if.o_imem_rdata, imem_q.pop_front());
    end
    if (bus_if.o_dmem_vld === 1'b1) begin
      if (dmem_q.size() == 0) check("dmem_unexpected_vld", 32'(bus_if.o_dmem_vld), 32'd0);
      else check("dmem_rdata", bus_if.o_dmem_rdata, dmem_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    grants;
    int    cyc;
    int    n;
    string seq;
    string exp_seq;

    rst_n = 1'b1;
    bus_if.i_imem_req   = 1'b0;
    bus_if.i_imem_addr  = '0;
    bus_if.i_flush      = 1'b0;
    bus_if.i_dmem_req   = 1'b0;
    bus_if.i_dmem_we    = 1'b0;
    bus_if.i_dmem_addr  = '0;
    bus_if.i_dmem_wdata = '0;
    bus_if.i_dmem_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;

    // Reset state
    probe();
    check("rst_busy",     32'(bus_if.o_busy), 32'd0);
    check("rst_bus_req",  32'(bus_if.o_bus_req), 32'd0);
    check("rst_imem_vld", 32'(bus_if.o_imem_vld), 32'd0);
    check("rst_dmem_vld", 32'(bus_if.o_dmem_vld), 32'd0);
    check("rst_bus_addr", bus_if.o_bus_addr, 32'd0);
    check("rst_imem_rdata", bus_if.o_imem_rdata, 32'd0);
    tick();

    // Single fetch with minimum latency
    bus_if.i_imem_req  = 1'b1;
    bus_if.i_imem_addr = 32'h10;
    probe();
    check("fetch_rdy_T",  32'(bus_if.o_imem_rdy), 32'd1);
    check("fetch_drdy_T", 32'(bus_if.o_dmem_rdy), 32'd0);
    imem_q.push_back(mem_word(32'h10));
    tick();
    bus_if.i_imem_req  = 1'b0;
    bus_if.i_imem_addr = 32'hFFFF_0000;
    probe();
    check("fetch_bus_req_T1",  32'(bus_if.o_bus_req), 32'd1);
    check("fetch_bus_addr_T1", bus_if.o_bus_addr, 32'h10);
    check("fetch_bus_we_T1",   32'(bus_if.o_bus_we), 32'd0);
    tick();
    probe();
    check("fetch_bus_req_T2", 32'(bus_if.o_bus_req), 32'd0);
    check("fetch_busy_T2",    32'(bus_if.o_busy), 32'd1);
    tick();
    probe();
    check("fetch_vld_T3",   32'(bus_if.o_imem_vld), 32'd1);
    check("fetch_rdata_T3", bus_if.o_imem_rdata, 32'h0013_0313);
    check("fetch_idle_T3",  32'(bus_if.o_busy), 32'd0);
    tick();
    probe();
    check("fetch_vld_pulse",  32'(bus_if.o_imem_vld), 32'd0);
    check("fetch_rdata_hold", bus_if.o_imem_rdata, 32'h0013_0313);
    tick();

    // Store: fields frozen after rdy, rdata forced to 0
    bus_if.i_dmem_req   = 1'b1;
    bus_if.i_dmem_we    = 1'b1;
    bus_if.i_dmem_addr  = 32'h100;
    bus_if.i_dmem_wdata = 32'hDEAD_BEEF;
    bus_if.i_dmem_wstrb = 4'b0011;
    probe();
    check("store_rdy",      32'(bus_if.o_dmem_rdy), 32'd1);
    check("store_imem_rdy", 32'(bus_if.o_imem_rdy), 32'd0);
    dmem_q.push_back(32'h0);
    tick();
    bus_if.i_dmem_req   = 1'b0;
    bus_if.i_dmem_we    = 1'b0;
    bus_if.i_dmem_addr  = 32'hBAD0;
    bus_if.i_dmem_wdata = 32'h0;
    bus_if.i_dmem_wstrb = 4'hF;
    probe();
    check("store_bus_req",   32'(bus_if.o_bus_req), 32'd1);
    check("store_bus_addr",  bus_if.o_bus_addr, 32'h100);
    check("store_bus_we",    32'(bus_if.o_bus_we), 32'd1);
    check("store_bus_wdata", bus_if.o_bus_wdata, 32'hDEAD_BEEF);
    check("store_bus_wstrb", 32'(bus_if.o_bus_wstrb), 32'h3);
    tick();
    probe();
    tick();
    probe();
    check("store_vld",      32'(bus_if.o_dmem_vld), 32'd1);
    check("store_rdata",    bus_if.o_dmem_rdata, 32'd0);
    check("store_imem_vld", 32'(bus_if.o_imem_vld), 32'd0);
    tick();

    // Load followed by a new request in the IDLE re-entry cycle
    bus_if.i_dmem_req  = 1'b1;
    bus_if.i_dmem_addr = 32'h200;
    probe();
    check("b2b_first_rdy", 32'(bus_if.o_dmem_rdy), 32'd1);
    dmem_q.push_back(mem_word(32'h200));
    tick();
    bus_if.i_dmem_req = 1'b0;
    probe();
    tick();
    probe();
    tick();
    bus_if.i_dmem_req  = 1'b1;
    bus_if.i_dmem_addr = 32'h204;
    probe();
    check("b2b_vld", 32'(bus_if.o_dmem_vld), 32'd1);
    check("b2b_rdy", 32'(bus_if.o_dmem_rdy), 32'd1);
    dmem_q.push_back(mem_word(32'h204));
    tick();
    bus_if.i_dmem_req = 1'b0;
    probe();
    check("b2b_bus_req",  32'(bus_if.o_bus_req), 32'd1);
    check("b2b_bus_addr", bus_if.o_bus_addr, 32'h204);
    tick();
    wait_dvld(8, "b2b_second_vld");
    tick();

    // Starvation: both ports request continuously
    bus_if.i_imem_req  = 1'b1;
    bus_if.i_imem_addr = 32'h80;
    bus_if.i_dmem_req  = 1'b1;
    bus_if.i_dmem_addr = 32'h300;
    grants = 0;
    cyc    = 0;
    seq    = "";
    while (grants < 10 && cyc < 100) begin
      probe();
      if (bus_if.o_imem_rdy === 1'b1) begin
        seq = {seq, "I"};
        imem_q.push_back(mem_word(32'h80));
        grants++;
      end
      if (bus_if.o_dmem_rdy === 1'b1) begin
        seq = {seq, "D"};
        dmem_q.push_back(mem_word(32'h300));
        grants++;
      end
      tick();
      cyc++;
    end
    bus_if.i_imem_req = 1'b0;
    bus_if.i_dmem_req = 1'b0;
    check("starve_grant_count", 32'(grants), 32'd10);
    exp_seq = "DDDDIDDDDI";
    for (int i = 0; i < 10; i++)
      check($sformatf("starve_grant_%0d", i), (i < seq.len()) ? 32'(seq[i]) : 32'd0, 32'(exp_seq[i]));
    n = 0;
    while ((imem_q.size() != 0 || dmem_q.size() != 0) && n < 20) begin
      probe();
      tick();
      n++;
    end
    check("starve_drain", 32'(imem_q.size() + dmem_q.size()), 32'd0);

    // Flush in REQ before any grant
    auto_bus = 1'b0;
    bus_if.i_imem_req  = 1'b1;
    bus_if.i_imem_addr = 32'h40;
    probe();
    check("flreq_rdy", 32'(bus_if.o_imem_rdy), 32'd1);
    tick();
    bus_if.i_imem_req = 1'b0;
    bus_if.i_flush    = 1'b1;
    probe();
    check("flreq_in_req", 32'(bus_if.o_bus_req), 32'd1);
    tick();
    bus_if.i_flush = 1'b0;
    probe();
    check("flreq_idle",       32'(bus_if.o_busy), 32'd0);
    check("flreq_no_bus_req", 32'(bus_if.o_bus_req), 32'd0);
    tick();
    probe();
    check("flreq_no_vld", 32'(bus_if.o_imem_vld), 32'd0);
    tick();

    // Flush while waiting for the response
    bus_if.i_imem_req  = 1'b1;
    bus_if.i_imem_addr = 32'h44;
    probe();
    check("flrsp_rdy", 32'(bus_if.o_imem_rdy), 32'd1);
    tick();
    bus_if.i_imem_req = 1'b0;
    m_gnt = 1'b1;
    probe();
    check("flrsp_bus_req", 32'(bus_if.o_bus_req), 32'd1);
    tick();
    m_gnt = 1'b0;
    bus_if.i_flush = 1'b1;
    probe();
    check("flrsp_in_rsp", 32'(bus_if.o_busy), 32'd1);
    tick();
    bus_if.i_flush = 1'b0;
    m_rvld  = 1'b1;
    m_rdata = 32'hCAFE_F00D;
    probe();
    tick();
    m_rvld = 1'b0;
    probe();
    check("flrsp_no_vld", 32'(bus_if.o_imem_vld), 32'd0);
    check("flrsp_idle",   32'(bus_if.o_busy), 32'd0);
    tick();
    auto_bus = 1'b1;
    bus_if.i_dmem_req  = 1'b1;
    bus_if.i_dmem_addr = 32'h500;
    probe();
    check("flrsp_data_rdy", 32'(bus_if.o_dmem_rdy), 32'd1);
    dmem_q.push_back(mem_word(32'h500));
    tick();
    bus_if.i_dmem_req = 1'b0;
    wait_dvld(8, "flrsp_data_vld");
    tick();

    // Reset while a data load is in RSP, then a late response
    auto_bus = 1'b0;
    bus_if.i_dmem_req  = 1'b1;
    bus_if.i_dmem_addr = 32'h600;
    probe();
    check("rstm_rdy", 32'(bus_if.o_dmem_rdy), 32'd1);
    tick();
    bus_if.i_dmem_req = 1'b0;
    m_gnt = 1'b1;
    probe();
    tick();
    m_gnt = 1'b0;
    rst_n = 1'b1;
    probe();
    check("rstm_busy_before", 32'(bus_if.o_busy), 32'd1);
    tick();
    rst_n   = 1'b0;
    m_rvld  = 1'b1;
    m_rdata = 32'h1234;
    probe();
    check("rstm_busy",       32'(bus_if.o_busy), 32'd0);
    check("rstm_bus_req",    32'(bus_if.o_bus_req), 32'd0);
    check("rstm_bus_addr",   bus_if.o_bus_addr, 32'd0);
    check("rstm_dmem_vld",   32'(bus_if.o_dmem_vld), 32'd0);
    check("rstm_dmem_rdata", bus_if.o_dmem_rdata, 32'd0);
    check("rstm_imem_rdata", bus_if.o_imem_rdata, 32'd0);
    tick();
    m_rvld = 1'b0;
    probe();
    check("rstm_late_vld",   32'(bus_if.o_dmem_vld), 32'd0);
    check("rstm_late_rdata", bus_if.o_dmem_rdata, 32'd0);
    tick();

    check("final_imem_q_empty", 32'(imem_q.size()), 32'd0);
    check("final_dmem_q_empty", 32'(dmem_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-outstanding memory bus between the Fetch instruction port and the load/store data port.
- Latches one request at a time and drives it onto the bus. Routes the response back to the owner with a registered valid.
- Data side has priority. A starvation counter forces an instruction grant after STARVE_LIMIT consecutive data wins.
- Sits between Fetch / Memory stage and the unified memory model.

Parameters:
- STARVE_LIMIT, 4: data wins allowed while the instruction port waits before the instruction port is forced (1..15).
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-high reset (1 = reset)
- i_imem_req  in  1  fetch request; held until o_imem_rdy
- i_imem_addr  in  ADDR_W  fetch address
- o_imem_rdy  out  1  one-cycle pulse: fetch request latched
- o_imem_vld  out  1  one-cycle pulse: o_imem_rdata valid
- o_imem_rdata  out  32  fetched instruction
- i_flush  in  1  cancel the outstanding/pending fetch (branch/trap)
- i_dmem_req  in  1  load/store request; held until o_dmem_rdy
- i_dmem_we  in  1  1 = store
- i_dmem_addr  in  ADDR_W  data address
- i_dmem_wdata  in  32  store data
- i_dmem_wstrb  in  4  byte enables
- o_dmem_rdy  out  1  one-cycle pulse: data request latched
- o_dmem_vld  out  1  one-cycle pulse: load data returned / store acknowledged
- o_dmem_rdata  out  32  load data (0 for stores)
- o_bus_req  out  1  bus request valid
- o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wstrb  out  1/ADDR_W/32/4  latched request fields
- i_bus_gnt  in  1  bus accepts request this cycle
- i_bus_rvld  in  1  bus response valid (reads and writes)
- i_bus_rdata  in  32  bus read data
- o_busy  out  1  FSM not IDLE

Behaviour:
- Reset (rst_n=1 at edge) is honoured in any state:
  - FSM returns to IDLE; starve_cnt=0; drop=0; owner=INSTR.
  - All outputs become 0.
  - Any in-flight bus transaction is abandoned; a late i_bus_rvld while in IDLE is ignored.
- FSM states:
  - IDLE: when a request is present, arbitrate. Latch the winner's fields and set owner. Pulse the winner's *_rdy in the same cycle. Go to REQ.
  - REQ: o_bus_req=1 with the latched fields. On i_bus_gnt go to RSP.
  - RSP: o_bus_req=0. On i_bus_rvld capture i_bus_rdata and go to IDLE.
- Arbitration in IDLE:
  - Only one requester: it wins.
  - Both requesting: data wins unless starve_cnt==STARVE_LIMIT, in which case instruction wins.
  - starve_cnt increments (saturating at STARVE_LIMIT) when data wins while i_imem_req=1. It clears when instruction wins.
- Response timing:
  - *_vld pulses and *_rdata are registered: they appear the cycle after i_bus_rvld, for the owner only.
  - rdata holds until the next response for that port.
  - Store responses drive o_dmem_rdata=0.
- Latency: request latched at cycle T (rdy) → bus req from T+1 → earliest gnt at T+1 → earliest rvld at T+2 → vld at T+3.
- The next request can be latched in the cycle IDLE is re-entered, the same cycle as the vld pulse, so back-to-back throughput is 1 transaction per 3 cycles minimum.
- Flush (affects the instruction side only):
  - In IDLE: blocks the instruction request that cycle (no rdy). A data request may still win.
  - In REQ with owner=INSTR and no i_bus_gnt that cycle: drop the request and return to IDLE. No bus transaction occurs.
  - In REQ with i_bus_gnt the same cycle, or in RSP with owner=INSTR: set drop=1. The response is consumed, o_imem_vld is suppressed, and drop clears on return to IDLE.
  - With owner=DATA: no effect.
- Request fields are frozen from latch until IDLE; input changes after rdy are ignored.
- i_bus_rvld outside RSP and i_bus_gnt outside REQ are ignored.

Test Plan:
- Single fetch: i_imem_req=1, addr=0x0000_0010; bus gnt 1 cycle later, rvld 2 cycles later with rdata=0x0013_0313 → o_imem_rdy pulse at T, o_bus_addr=0x10 at T+1, o_imem_vld=1 with rdata=0x0013_0313 at T+3.
- Store: we=1, addr=0x100, wdata=0xDEAD_BEEF, wstrb=4'b0011 → bus fields match exactly; o_dmem_vld pulse with o_dmem_rdata=0; o_imem_vld stays 0.
- Starvation: both ports request continuously, STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I; starve_cnt never exceeds 4.
- Flush in REQ before gnt → no bus transaction, back to IDLE next cycle. Flush in RSP → rvld consumed, o_imem_vld never pulses; a following data request completes normally.
- Reset mid-RSP (owner=DATA): rst_n=1 for 1 cycle → all outputs 0, o_busy=0. A late rvld=1 with rdata=0x1234 produces no o_dmem_vld.
- Simultaneous: IDLE-entry cycle with a vld pulse and a new dmem request → o_dmem_vld and o_dmem_rdy both high in that cycle, bus req asserted the next cycle.
